// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator sequencer and the FND display path.
package elevator_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_FLOOR1     = 3'd1,
    ST_FLOOR2     = 3'd2,
    ST_GOING_TO_1 = 3'd3,
    ST_GOING_TO_2 = 3'd4
  } state_t;

  // Floor the car is at or heading to, as a request-bit mask; calls matching it are dropped.
  function automatic logic [1:0] dest_mask(input state_t s);
    case (s)
      ST_FLOOR2, ST_GOING_TO_2: dest_mask = 2'b10;
      default:                  dest_mask = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/elevator_seq_ctrl_tick_gen.sv
// Countdown timebase: pulses tick every TICK_DIV cycles, restartable by clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/elevator_seq_ctrl.sv
// Two-floor elevator sequencer: call latching, travel/dwell FSM and the
// state/countdown pair consumed by the FND display controller.
module elevator_seq_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned TRAVEL_SEC = 5,
  parameter int unsigned DWELL_SEC  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               call1,
  input  logic               call2,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   counting_value,
  output logic [1:0]         req_pending,
  output logic               arrive
);

  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_SEC);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_SEC);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cv, w_cv_nxt;
  logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
  logic [1:0]       r_req, w_req_nxt;
  logic             r_arrive, w_arrive_nxt;
  logic             r_call1_d, r_call2_d;
  logic [1:0]       w_rise;
  logic             w_tick;
  logic             w_dwell_done;
  logic             w_state_chg;

  assign w_rise       = {call2 & ~r_call2_d, call1 & ~r_call1_d};
  assign w_dwell_done = (r_dwell == '0);
  assign w_state_chg  = (w_state_nxt != r_state);

  // Restarting the prescaler on every transition makes each phase a whole number of ticks.
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_state_chg),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cv_nxt     = r_cv;
    w_dwell_nxt  = r_dwell;
    w_arrive_nxt = 1'b0;
    w_req_nxt    = r_req | (w_rise & ~dest_mask(r_state));
    case (r_state)
      ST_IDLE: begin
        if (r_req[1]) begin
          w_state_nxt = ST_GOING_TO_2;
          w_cv_nxt    = TRAVEL_LD;
        end
      end
      ST_FLOOR1: begin
        if (w_dwell_done) begin
          if (r_req[1]) begin
            w_state_nxt = ST_GOING_TO_2;
            w_cv_nxt    = TRAVEL_LD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_tick) begin
          w_dwell_nxt = r_dwell - CNT_W'(1);
        end
      end
      ST_FLOOR2: begin
        if (w_dwell_done) begin
          if (r_req[0]) begin
            w_state_nxt = ST_GOING_TO_1;
            w_cv_nxt    = TRAVEL_LD;
          end
        end else if (w_tick) begin
          w_dwell_nxt = r_dwell - CNT_W'(1);
        end
      end
      ST_GOING_TO_1, ST_GOING_TO_2: begin
        if (w_tick) begin
          if (r_cv <= CNT_W'(1)) begin
            w_state_nxt  = (r_state == ST_GOING_TO_1) ? ST_FLOOR1 : ST_FLOOR2;
            w_cv_nxt     = '0;
            w_dwell_nxt  = DWELL_LD;
            w_arrive_nxt = 1'b1;
            if (r_state == ST_GOING_TO_1) w_req_nxt[0] = 1'b0;
            else                          w_req_nxt[1] = 1'b0;
          end else begin
            w_cv_nxt = r_cv - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cv_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cv      <= '0;
      r_dwell   <= '0;
      r_req     <= '0;
      r_arrive  <= 1'b0;
      r_call1_d <= 1'b0;
      r_call2_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cv      <= w_cv_nxt;
      r_dwell   <= w_dwell_nxt;
      r_req     <= w_req_nxt;
      r_arrive  <= w_arrive_nxt;
      r_call1_d <= call1;
      r_call2_d <= call2;
    end
  end

  assign state          = r_state;
  assign counting_value = r_cv;
  assign req_pending    = r_req;
  assign arrive         = r_arrive;

endmodule
